// File: rtl/digital_modulator.sv
// Bit-rate baseband source plus ASK/FSK/PSK/baseband selector over externally supplied carriers.
// Optional build macro MOD_PN_GEN_EN replaces data_in with an internal x^7+x^6+1 PN generator.
module digital_modulator #(
  parameter int unsigned BIT_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] mod_sel,
  input  logic [9:0] carrier_a,
  input  logic [9:0] carrier_b,
  input  logic [9:0] carrier_c,
  input  logic       data_in,
  output logic [9:0] mod_out,
  output logic       bit_out,
  output logic       bit_tick
);

  localparam int unsigned CNT_W = 20;
  localparam int unsigned SMP_W = 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);
  localparam logic [SMP_W-1:0] SMP_MID  = SMP_W'(512);
  localparam logic [SMP_W-1:0] SMP_FULL = SMP_W'(1023);
  localparam logic [SMP_W-1:0] SMP_ZERO = SMP_W'(0);

  typedef enum logic [1:0] {
    MODE_ASK = 2'b00,
    MODE_FSK = 2'b01,
    MODE_PSK = 2'b10,
    MODE_BB  = 2'b11
  } mode_e;

  logic [CNT_W-1:0] cnt;
  mode_e            mode_q;
  logic             boundary_c;
  logic             next_bit_c;
  logic [SMP_W-1:0] sample_c;

  assign boundary_c = en && (cnt == CNT_LAST);

`ifdef MOD_PN_GEN_EN
  localparam logic BIT_RST = 1'b1;
  localparam int unsigned LFSR_W = 7;

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_next_c;
  logic              unused_data_in;

  assign unused_data_in = data_in;
  assign lfsr_next_c    = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
  assign next_bit_c     = lfsr_next_c[6];

  // PN register advances once per bit boundary; seed is all ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= {LFSR_W{1'b1}};
    end else if (boundary_c) begin
      lfsr <= lfsr_next_c;
    end
  end
`else
  localparam logic BIT_RST = 1'b0;

  assign next_bit_c = data_in;
`endif

  // Pure selection between carriers and constants; idle level while disabled
  always_comb begin
    sample_c = SMP_MID;
    if (en) begin
      unique case (mode_q)
        MODE_ASK: sample_c = bit_out ? carrier_b : SMP_MID;
        MODE_FSK: sample_c = bit_out ? carrier_b : carrier_a;
        MODE_PSK: sample_c = bit_out ? carrier_b : carrier_c;
        MODE_BB:  sample_c = bit_out ? SMP_FULL  : SMP_ZERO;
        default:  sample_c = SMP_MID;
      endcase
    end
  end

  // Bit timing, boundary-latched bit/mode, registered sample output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      bit_tick <= 1'b0;
      bit_out  <= BIT_RST;
      mode_q   <= MODE_ASK;
      mod_out  <= SMP_MID;
    end else begin
      bit_tick <= boundary_c;
      mod_out  <= sample_c;
      if (en) begin
        cnt <= boundary_c ? '0 : cnt + CNT_W'(1);
      end
      if (boundary_c) begin
        bit_out <= next_bit_c;
        mode_q  <= mode_e'(mod_sel);
      end
    end
  end

endmodule

// File: tb/tb_digital_modulator.sv
// Randomized bench for digital_modulator with an enabled-edge-count reference model.
module tb_digital_modulator;

  localparam int BIT_DIV = 4;
  localparam int N_RAND  = 3000;

`ifdef MOD_PN_GEN_EN
  localparam logic RST_BIT = 1'b1;
  localparam int   BIT2 = 1;
  localparam int   BIT4 = 1;
`else
  localparam logic RST_BIT = 1'b0;
  localparam int   BIT2 = 0;
  localparam int   BIT4 = 0;
`endif

  logic       clk;
  logic       reset_n;
  logic       en;
  logic [1:0] mod_sel;
  logic [9:0] carrier_a;
  logic [9:0] carrier_b;
  logic [9:0] carrier_c;
  logic       data_in;
  logic [9:0] mod_out;
  logic       bit_out;
  logic       bit_tick;

  int total = 0;
  int bad   = 0;
  logic chk_on = 1'b0;

  digital_modulator #(.BIT_DIV(BIT_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .mod_sel(mod_sel),
    .carrier_a(carrier_a), .carrier_b(carrier_b), .carrier_c(carrier_c),
    .data_in(data_in), .mod_out(mod_out), .bit_out(bit_out), .bit_tick(bit_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Spec mapping table from (bit, mode) to output sample
  function automatic logic [9:0] expect_sample(input logic b, input logic [1:0] mode,
                                               input logic [9:0] a, input logic [9:0] bb,
                                               input logic [9:0] c);
    case (mode)
      2'd0:    return b ? bb : 10'd512;
      2'd1:    return b ? bb : a;
      2'd2:    return b ? bb : c;
      default: return b ? 10'd1023 : 10'd0;
    endcase
  endfunction

`ifdef MOD_PN_GEN_EN
  // Bit stream x[n] = x[n-7] ^ x[n-6]; x[0..6] is the all-ones seed, bit k is x[k]
  logic pn_x [0:140];
  initial begin
    for (int i = 0; i < 7; i++) pn_x[i] = 1'b1;
    for (int i = 7; i <= 140; i++) pn_x[i] = pn_x[i-7] ^ pn_x[i-6];
  end
  function automatic logic next_bit(input int k);
    return pn_x[((k - 1) % 127) + 1];
  endfunction
`else
  function automatic logic next_bit(input int k);
    if (k < 0) return 1'b0;
    return data_in;
  endfunction
`endif

  // Reference: boundaries fall on every BIT_DIV-th enabled edge since reset
  int         m_edges;
  logic       m_bit;
  logic [1:0] m_mode;
  logic [9:0] m_out;
  logic       m_tick;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_edges <= 0;
      m_bit   <= RST_BIT;
      m_mode  <= 2'd0;
      m_out   <= 10'd512;
      m_tick  <= 1'b0;
    end else begin
      m_out  <= en ? expect_sample(m_bit, m_mode, carrier_a, carrier_b, carrier_c) : 10'd512;
      m_tick <= 1'b0;
      if (en) begin
        m_edges <= m_edges + 1;
        if ((m_edges + 1) % BIT_DIV == 0) begin
          m_tick <= 1'b1;
          m_mode <= mod_sel;
          m_bit  <= next_bit((m_edges + 1) / BIT_DIV);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("mod_out", int'(mod_out), int'(m_out));
      check("bit_out", int'(bit_out), int'(m_bit));
      check("bit_tick", int'(bit_tick), int'(m_tick));
    end
  end

  initial begin
    reset_n = 1'b0; en = 1'b0; mod_sel = 2'd0; data_in = 1'b0;
    carrier_a = 10'd100; carrier_b = 10'd900; carrier_c = 10'd300;
    repeat (3) @(negedge clk);
    check("rst_mod_out", int'(mod_out), 512);
    check("rst_bit_tick", int'(bit_tick), 0);
    check("rst_bit_out", int'(bit_out), int'(RST_BIT));
`ifdef MOD_PN_GEN_EN
    for (int i = 1; i <= 6; i++) check("pn_head_one", int'(pn_x[i]), 1);
    check("pn_bit7", int'(pn_x[7]), 0);
`endif
    chk_on = 1'b1;

    // First bit: baseband requested, data_in=1
    reset_n = 1'b1; en = 1'b1; mod_sel = 2'd3; data_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("first_tick_early", int'(bit_tick), 0);
    end
    @(negedge clk);
    check("first_tick", int'(bit_tick), 1);
    check("first_bit", int'(bit_out), 1);
    data_in = 1'b0;
    @(negedge clk);
    check("bb_one", int'(mod_out), 1023);
    check("tick_one_cycle", int'(bit_tick), 0);

    // Second bit toggles data_in
    repeat (2) @(negedge clk);
    @(negedge clk);
    check("second_tick", int'(bit_tick), 1);
    check("second_bit", int'(bit_out), BIT2);
    @(negedge clk);
    check("bb_second", int'(mod_out), BIT2 ? 1023 : 0);

    // FSK captured at next boundary, bit 1 -> carrier_b
    data_in = 1'b1; mod_sel = 2'd1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    check("fsk_tick", int'(bit_tick), 1);
    @(negedge clk);
    check("fsk_one", int'(mod_out), 900);

    // Ten disabled cycles mid-bit delay the boundary by ten cycles
    data_in = 1'b0; en = 1'b0;
    @(negedge clk);
    check("gap_idle", int'(mod_out), 512);
    repeat (9) @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("gap_tick_early", int'(bit_tick), 0);
    end
    @(negedge clk);
    check("gap_tick_late", int'(bit_tick), 1);
    @(negedge clk);
    check("fsk_bit4", int'(mod_out), BIT4 ? 900 : 100);

    // Asynchronous reset between edges, mid-bit
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_mod_out", int'(mod_out), 512);
    check("async_bit_tick", int'(bit_tick), 0);
    check("async_bit_out", int'(bit_out), int'(RST_BIT));
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_early", int'(bit_tick), 0);
    end
    @(negedge clk);
    check("post_rst_tick", int'(bit_tick), 1);

    // Random traffic: carriers, enable gaps, mode requests, data, rare reset pulses
    for (int n = 0; n < N_RAND; n++) begin
      @(negedge clk);
      en        = ($urandom_range(0, 9) != 0);
      carrier_a = 10'($urandom);
      carrier_b = 10'($urandom);
      carrier_c = 10'($urandom);
      data_in   = 1'($urandom);
      if ($urandom_range(0, 5) == 0) mod_sel = 2'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
    end
    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
